// File: rtl/wid_pkg.sv
// Shared constants, ratio helper and state encoding for the word unpacker.
package wid_pkg;

    localparam int WID_WORD_W = 16;
    localparam int WID_BYTE_W = 8;

    function automatic int wid_ratio(input int word_w, input int byte_w);
        return word_w / byte_w;
    endfunction

    typedef enum logic {
        WID_IDLE = 1'b0,
        WID_SEND = 1'b1
    } wid_unpack_state_e;

endpackage

// File: rtl/wid_word_unpacker.sv
// Splits one wide word into RATIO narrow beats over a valid/ready stream,
// accepting the next word in the same cycle the last beat is taken.
module wid_word_unpacker
    import wid_pkg::*;
#(
    parameter int WORD_W    = WID_WORD_W,
    parameter int BYTE_W    = WID_BYTE_W,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int RATIO = wid_ratio(WORD_W, BYTE_W);
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((WORD_W % BYTE_W) != 0 || RATIO < 2 || RATIO > 16) begin : g_bad_params
            $error("wid_word_unpacker: WORD_W must be RATIO*BYTE_W with 2 <= RATIO <= 16");
        end
    endgenerate

    wid_unpack_state_e state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BYTE_W-1:0] slice;
    logic              accept;
    logic              xfer;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WID_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic; flush overrides both accept and beat advance
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        accept  = in_valid && in_ready;
        xfer    = out_valid && out_ready;
        if (flush) begin
            state_d = WID_IDLE;
            idx_d   = '0;
        end else if (accept) begin
            state_d = WID_SEND;
            idx_d   = '0;
            word_d  = in_data;
        end else if (xfer) begin
            if (out_last) begin
                state_d = WID_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Slice select straight from the held word, so out_data never sees in_data
    always_comb begin
        slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice = (MSB_FIRST != 0) ? word_q[WORD_W-1-i*BYTE_W -: BYTE_W]
                                         : word_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q == WID_SEND);
        out_valid = busy;
        out_last  = busy && (idx_q == LAST_IDX);
        out_data  = busy ? slice : '0;
        in_ready  = !flush && (!busy || (out_ready && out_last));
    end

endmodule
